// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: Y86 stage register (load / stall / bubble) with valid flag, sticky conflict flag; PIPE_STAGE_PERF_EN adds counters.
// Latency: 1 cycle; every output is a flop, with no combinational path from inputs.
// Backpressure: stall holds all contents and wins over bubble; bubble injects a fully cleared NOP.
module pipe_stage_reg #(
  parameter int          DATA_W       = 64,
  parameter int          NVAL         = 3,
  parameter int          NREG         = 4,
  parameter logic [3:0]  BUBBLE_ICODE = 4'h1,
  parameter logic [3:0]  RNONE        = 4'hF,
  parameter int          CNT_W        = 32
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   stall,
  input  logic                   bubble,
  input  logic [1:0]             in_stat,
  input  logic [3:0]             in_icode,
  input  logic [3:0]             in_ifun,
  input  logic [NVAL*DATA_W-1:0] in_val,
  input  logic [NREG*4-1:0]      in_reg,
  output logic [1:0]             out_stat,
  output logic [3:0]             out_icode,
  output logic [3:0]             out_ifun,
  output logic [NVAL*DATA_W-1:0] out_val,
  output logic [NREG*4-1:0]      out_reg,
  output logic                   out_valid,
  output logic                   ctl_err
`ifdef PIPE_STAGE_PERF_EN
  ,
  output logic [CNT_W-1:0]       stall_cnt,
  output logic [CNT_W-1:0]       bubble_cnt
`endif
);

  // Every register ID is cleared to RNONE so a bubble can never match a forwarding source.
  localparam logic [NREG*4-1:0] REG_NONE = {NREG{RNONE}};

  // Payload and valid: reset and bubble share the same NOP image; stall has top priority.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_stat  <= 2'b00;
      out_icode <= BUBBLE_ICODE;
      out_ifun  <= 4'h0;
      out_val   <= '0;
      out_reg   <= REG_NONE;
      out_valid <= 1'b0;
    end else if (stall) begin
      out_stat  <= out_stat;
      out_icode <= out_icode;
      out_ifun  <= out_ifun;
      out_val   <= out_val;
      out_reg   <= out_reg;
      out_valid <= out_valid;
    end else if (bubble) begin
      out_stat  <= 2'b00;
      out_icode <= BUBBLE_ICODE;
      out_ifun  <= 4'h0;
      out_val   <= '0;
      out_reg   <= REG_NONE;
      out_valid <= 1'b0;
    end else begin
      out_stat  <= in_stat;
      out_icode <= in_icode;
      out_ifun  <= in_ifun;
      out_val   <= in_val;
      out_reg   <= in_reg;
      out_valid <= 1'b1;
    end
  end

  // Sticky flag for a simultaneous stall+bubble request; only reset clears it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctl_err <= 1'b0;
    end else if (stall && bubble) begin
      ctl_err <= 1'b1;
    end
  end

`ifdef PIPE_STAGE_PERF_EN
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  // Saturating stall counter: counts every stalled edge, including conflicts.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
    end else if (stall && (stall_cnt != CNT_MAX)) begin
      stall_cnt <= stall_cnt + CNT_ONE;
    end
  end

  // Saturating bubble counter: only bubbles that actually take effect (stall low).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bubble_cnt <= '0;
    end else if (!stall && bubble && (bubble_cnt != CNT_MAX)) begin
      bubble_cnt <= bubble_cnt + CNT_ONE;
    end
  end
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
module tb_pipe_stage_reg;

  logic         clk;
  logic         rst_n;
  logic         stall;
  logic         bubble;
  logic [1:0]   in_stat;
  logic [3:0]   in_icode;
  logic [3:0]   in_ifun;
  logic [191:0] in_val;
  logic [15:0]  in_reg;
  logic [1:0]   out_stat;
  logic [3:0]   out_icode;
  logic [3:0]   out_ifun;
  logic [191:0] out_val;
  logic [15:0]  out_reg;
  logic         out_valid;
  logic         ctl_err;

  int checks   = 0;
  int failures = 0;

  // Expected image of the payload (stat, icode, ifun, val, reg, valid).
  logic [1:0]   e_stat;
  logic [3:0]   e_icode;
  logic [3:0]   e_ifun;
  logic [191:0] e_val;
  logic [15:0]  e_reg;
  logic         e_valid;

`ifdef PIPE_STAGE_PERF_EN
  logic [31:0]  stall_cnt;
  logic [31:0]  bubble_cnt;
  logic [1:0]   s_stat;
  logic [3:0]   s_icode;
  logic [3:0]   s_ifun;
  logic [191:0] s_val;
  logic [15:0]  s_reg;
  logic         s_valid;
  logic         s_err;
  logic [3:0]   s_stall_cnt;
  logic [3:0]   s_bubble_cnt;
`endif

  pipe_stage_reg dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .bubble(bubble),
    .in_stat(in_stat), .in_icode(in_icode), .in_ifun(in_ifun),
    .in_val(in_val), .in_reg(in_reg),
    .out_stat(out_stat), .out_icode(out_icode), .out_ifun(out_ifun),
    .out_val(out_val), .out_reg(out_reg), .out_valid(out_valid),
    .ctl_err(ctl_err)
`ifdef PIPE_STAGE_PERF_EN
    , .stall_cnt(stall_cnt), .bubble_cnt(bubble_cnt)
`endif
  );

`ifdef PIPE_STAGE_PERF_EN
  pipe_stage_reg #(.CNT_W(4)) dut_sat (
    .clk(clk), .rst_n(rst_n), .stall(stall), .bubble(bubble),
    .in_stat(in_stat), .in_icode(in_icode), .in_ifun(in_ifun),
    .in_val(in_val), .in_reg(in_reg),
    .out_stat(s_stat), .out_icode(s_icode), .out_ifun(s_ifun),
    .out_val(s_val), .out_reg(s_reg), .out_valid(s_valid),
    .ctl_err(s_err), .stall_cnt(s_stall_cnt), .bubble_cnt(s_bubble_cnt)
  );
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One clock edge, then settle 1 time unit past it before sampling.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [1:0] st, input logic [3:0] ic, input logic [3:0] fn,
                       input logic [63:0] v0, input logic [63:0] v1, input logic [63:0] v2,
                       input logic [15:0] rg);
    in_stat  = st;
    in_icode = ic;
    in_ifun  = fn;
    in_val   = {v2, v1, v0};
    in_reg   = rg;
  endtask

  task automatic expect_bubble();
    e_stat  = 2'b00;
    e_icode = 4'h1;
    e_ifun  = 4'h0;
    e_val   = '0;
    e_reg   = 16'hFFFF;
    e_valid = 1'b0;
  endtask

  task automatic expect_inputs();
    e_stat  = in_stat;
    e_icode = in_icode;
    e_ifun  = in_ifun;
    e_val   = in_val;
    e_reg   = in_reg;
    e_valid = 1'b1;
  endtask

  task automatic test_reset();
    drive(2'b00, 4'h6, 4'h0, 64'h1, 64'h2, 64'h3, 16'h1234);
    tick();
    checks++;
    if (out_icode !== 4'h6 || out_valid !== 1'b1) begin
      failures++;
      $display("FAIL reset_preload icode=%h valid=%b required icode=6 valid=1", out_icode, out_valid);
    end
    // Assert reset mid-cycle, also while a stall is requested.
    stall = 1'b1;
    #3 rst_n = 1'b0;
    #1;
    expect_bubble();
    checks++;
    if ({out_stat, out_icode, out_ifun, out_val, out_reg, out_valid} !==
        {e_stat, e_icode, e_ifun, e_val, e_reg, e_valid}) begin
      failures++;
      $display("FAIL reset_payload stat=%h icode=%h ifun=%h reg=%h val0=%h valid=%b required 0 1 0 ffff 0 0",
               out_stat, out_icode, out_ifun, out_reg, out_val[63:0], out_valid);
    end
    checks++;
    if (ctl_err !== 1'b0) begin
      failures++;
      $display("FAIL reset_ctl_err got=%b required=0", ctl_err);
    end
`ifdef PIPE_STAGE_PERF_EN
    checks++;
    if (stall_cnt !== 32'd0 || bubble_cnt !== 32'd0) begin
      failures++;
      $display("FAIL reset_counters stall=%0d bubble=%0d required 0 0", stall_cnt, bubble_cnt);
    end
`endif
    #2 rst_n = 1'b1;
    stall = 1'b0;
    drive(2'b11, 4'h2, 4'h5, 64'hAB, 64'hCD, 64'hEF, 16'h5A5A);
    tick();
    expect_inputs();
    checks++;
    if ({out_stat, out_icode, out_ifun, out_val, out_reg, out_valid} !==
        {e_stat, e_icode, e_ifun, e_val, e_reg, e_valid}) begin
      failures++;
      $display("FAIL reset_first_load icode=%h reg=%h valid=%b required icode=2 reg=5a5a valid=1",
               out_icode, out_reg, out_valid);
    end
  endtask

  task automatic test_load();
    drive(2'b00, 4'h6, 4'h1, 64'h10, 64'hAAAA_0000_5555_1111, 64'hDEAD_BEEF_0000_0042, 16'hF3F2);
    tick();
    expect_inputs();
    checks++;
    if ({out_stat, out_icode, out_ifun, out_val, out_reg, out_valid} !==
        {e_stat, e_icode, e_ifun, e_val, e_reg, e_valid}) begin
      failures++;
      $display("FAIL load_opq icode=%h ifun=%h val0=%h reg=%h valid=%b required 6 1 10 f3f2 1",
               out_icode, out_ifun, out_val[63:0], out_reg, out_valid);
    end
    drive(2'b10, 4'h3, 4'h0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 64'h8000_0000_0000_0001, 16'h0F87);
    tick();
    expect_inputs();
    checks++;
    if ({out_stat, out_icode, out_ifun, out_val, out_reg, out_valid} !==
        {e_stat, e_icode, e_ifun, e_val, e_reg, e_valid}) begin
      failures++;
      $display("FAIL load_irmovq stat=%h icode=%h val2=%h reg=%h required 2 3 8000000000000001 0f87",
               out_stat, out_icode, out_val[191:128], out_reg);
    end
  endtask

  task automatic test_stall();
    // e_* still holds the last loaded image.
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(2'(i), 4'h7 + 4'(i), 4'h2, 64'(i + 100), 64'h99, 64'h77, 16'h1111 * 16'(i + 1));
      tick();
      checks++;
      if ({out_stat, out_icode, out_ifun, out_val, out_reg, out_valid} !==
          {e_stat, e_icode, e_ifun, e_val, e_reg, e_valid}) begin
        failures++;
        $display("FAIL stall_hold_%0d icode=%h reg=%h valid=%b required icode=%h reg=%h valid=1",
                 i, out_icode, out_reg, out_valid, e_icode, e_reg);
      end
    end
`ifdef PIPE_STAGE_PERF_EN
    checks++;
    if (stall_cnt !== 32'd3) begin
      failures++;
      $display("FAIL stall_cnt got=%0d required=3", stall_cnt);
    end
`endif
    stall = 1'b0;
    tick();
    expect_inputs();
    checks++;
    if ({out_stat, out_icode, out_ifun, out_val, out_reg, out_valid} !==
        {e_stat, e_icode, e_ifun, e_val, e_reg, e_valid}) begin
      failures++;
      $display("FAIL stall_release icode=%h reg=%h required icode=9 reg=3333", out_icode, out_reg);
    end
  endtask

  task automatic test_bubble();
    drive(2'b00, 4'h6, 4'h1, 64'h10, 64'h20, 64'h30, 16'hF3F2);
    tick();
    bubble = 1'b1;
    tick();
    bubble = 1'b0;
    expect_bubble();
    checks++;
    if ({out_stat, out_icode, out_ifun, out_val, out_reg, out_valid} !==
        {e_stat, e_icode, e_ifun, e_val, e_reg, e_valid}) begin
      failures++;
      $display("FAIL bubble_nop stat=%h icode=%h ifun=%h val0=%h reg=%h valid=%b required 0 1 0 0 ffff 0",
               out_stat, out_icode, out_ifun, out_val[63:0], out_reg, out_valid);
    end
`ifdef PIPE_STAGE_PERF_EN
    checks++;
    if (bubble_cnt !== 32'd1 || stall_cnt !== 32'd3) begin
      failures++;
      $display("FAIL bubble_cnt bubble=%0d stall=%0d required 1 3", bubble_cnt, stall_cnt);
    end
`endif
  endtask

  task automatic test_conflict();
    drive(2'b01, 4'hA, 4'h0, 64'h5, 64'h6, 64'h7, 16'h4F4F);
    tick();
    expect_inputs();
    stall  = 1'b1;
    bubble = 1'b1;
    drive(2'b00, 4'hB, 4'h3, 64'h0, 64'h0, 64'h0, 16'h0000);
    tick();
    stall  = 1'b0;
    bubble = 1'b0;
    checks++;
    if ({out_stat, out_icode, out_ifun, out_val, out_reg, out_valid} !==
        {e_stat, e_icode, e_ifun, e_val, e_reg, e_valid}) begin
      failures++;
      $display("FAIL conflict_hold icode=%h reg=%h valid=%b required icode=a reg=4f4f valid=1",
               out_icode, out_reg, out_valid);
    end
    checks++;
    if (ctl_err !== 1'b1) begin
      failures++;
      $display("FAIL conflict_set got=%b required=1", ctl_err);
    end
`ifdef PIPE_STAGE_PERF_EN
    checks++;
    if (stall_cnt !== 32'd4 || bubble_cnt !== 32'd1) begin
      failures++;
      $display("FAIL conflict_counts stall=%0d bubble=%0d required 4 1", stall_cnt, bubble_cnt);
    end
`endif
    for (int i = 0; i < 5; i++) begin
      drive(2'b00, 4'(i + 2), 4'h0, 64'(i), 64'h0, 64'h0, 16'h1230 + 16'(i));
      tick();
      checks++;
      if (ctl_err !== 1'b1 || out_icode !== 4'(i + 2) || out_valid !== 1'b1) begin
        failures++;
        $display("FAIL conflict_sticky_%0d err=%b icode=%h valid=%b required err=1 icode=%h valid=1",
                 i, ctl_err, out_icode, out_valid, 4'(i + 2));
      end
    end
    #3 rst_n = 1'b0;
    #1;
    checks++;
    if (ctl_err !== 1'b0 || out_valid !== 1'b0) begin
      failures++;
      $display("FAIL conflict_clear err=%b valid=%b required 0 0", ctl_err, out_valid);
    end
    #2 rst_n = 1'b1;
  endtask

`ifdef PIPE_STAGE_PERF_EN
  task automatic test_saturation();
    stall = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (i == 14) begin
        checks++;
        if (s_stall_cnt !== 4'd15) begin
          failures++;
          $display("FAIL sat_reach got=%0d required=15", s_stall_cnt);
        end
      end
    end
    stall = 1'b0;
    checks++;
    if (s_stall_cnt !== 4'd15) begin
      failures++;
      $display("FAIL sat_hold got=%0d required=15", s_stall_cnt);
    end
    checks++;
    if (stall_cnt !== 32'd20) begin
      failures++;
      $display("FAIL sat_wide got=%0d required=20", stall_cnt);
    end
  endtask
`endif

  initial begin
    rst_n  = 1'b0;
    stall  = 1'b0;
    bubble = 1'b0;
    drive(2'b00, 4'h0, 4'h0, 64'h0, 64'h0, 64'h0, 16'h0);
    #12 rst_n = 1'b1;
    test_reset();
    test_load();
    test_stall();
    test_bubble();
    test_conflict();
`ifdef PIPE_STAGE_PERF_EN
    test_saturation();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
